// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared AXI-Stream helpers: count-width function and lane fill value
package axis_pkg;

  localparam bit AXIS_LANE_ZERO = 1'b0;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_byte_packer_if.sv
// rtl/axis_byte_packer_if.sv - narrow input stream and packed output stream of the byte packer
interface axis_byte_packer_if #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
);
  logic [IN_WIDTH-1:0]       s_axis_tdata;
  logic                      s_axis_tvalid;
  logic                      s_axis_tlast;
  logic                      s_axis_tready;
  logic [IN_WIDTH*RATIO-1:0] m_axis_tdata;
  logic [RATIO-1:0]          m_axis_tkeep;
  logic                      m_axis_tlast;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;

  // slave: the packer itself; master: the surrounding source and sink
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );
endinterface

// File: rtl/axis_byte_packer.sv
// rtl/axis_byte_packer.sv - AXI-Stream upsizer packing RATIO narrow beats into one keep-qualified word
module axis_byte_packer
  import axis_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  axis_byte_packer_if.slave   bus
);

  localparam int CW = clog2_min1(RATIO);
  localparam int OW = IN_WIDTH * RATIO;

  logic [CW-1:0]    cnt;
  logic [OW-1:0]    acc;
  logic [RATIO-1:0] keep_acc;
  logic [OW-1:0]    merged_data;
  logic [RATIO-1:0] merged_keep;
  logic             xfer;
  logic             complete;

  // Ready depends only on the output register, never on the input side
  assign bus.s_axis_tready = !bus.m_axis_tvalid || bus.m_axis_tready;
  assign xfer     = bus.s_axis_tvalid && bus.s_axis_tready;
  assign complete = xfer && ((cnt == CW'(RATIO - 1)) || bus.s_axis_tlast);

  always_comb begin
    merged_data = acc;
    merged_keep = keep_acc | (RATIO'(1) << cnt);
    merged_data[int'(cnt)*IN_WIDTH +: IN_WIDTH] = bus.s_axis_tdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt               <= '0;
      acc               <= {OW{AXIS_LANE_ZERO}};
      keep_acc          <= '0;
      bus.m_axis_tdata  <= {OW{AXIS_LANE_ZERO}};
      bus.m_axis_tkeep  <= '0;
      bus.m_axis_tlast  <= 1'b0;
      bus.m_axis_tvalid <= 1'b0;
    end else if (complete) begin
      // Loading over a draining word keeps tvalid high for full-rate streaming
      bus.m_axis_tdata  <= merged_data;
      bus.m_axis_tkeep  <= merged_keep;
      bus.m_axis_tlast  <= bus.s_axis_tlast;
      bus.m_axis_tvalid <= 1'b1;
      cnt               <= '0;
      acc               <= {OW{AXIS_LANE_ZERO}};
      keep_acc          <= '0;
    end else begin
      if (bus.m_axis_tvalid && bus.m_axis_tready)
        bus.m_axis_tvalid <= 1'b0;
      if (xfer) begin
        acc      <= merged_data;
        keep_acc <= merged_keep;
        cnt      <= cnt + CW'(1);
      end
    end
  end

endmodule
